// File: rtl/dmem_dual_responder.sv
// Dual-issue data-memory responder.
// Two MEM-stage lanes share one word array split into an even bank and an odd bank.
// A same-bank pair is split over two cycles: lane 1 goes first, and lane 2 waits in a
// replay register. Read data comes back registered, with a one-cycle valid pulse per lane.
module dmem_dual_responder #(
   parameter int D_WIDTH = 32,
   parameter int AW      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_Valid1,
   input  logic               i_WE1,
   input  logic [D_WIDTH-1:0] i_Addr1,
   input  logic [D_WIDTH-1:0] i_WData1,
   input  logic               i_Valid2,
   input  logic               i_WE2,
   input  logic [D_WIDTH-1:0] i_Addr2,
   input  logic [D_WIDTH-1:0] i_WData2,
   output logic               o_Ready,
   output logic               o_RValid1,
   output logic [D_WIDTH-1:0] o_RD1,
   output logic               o_RValid2,
   output logic [D_WIDTH-1:0] o_RD2,
   output logic               o_Stall
);

   localparam int RW      = AW - 1;          // row-index width inside one bank
   localparam int DEPTH_B = 2 ** RW;         // words per bank

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_REPLAY = 1'b1;

   logic               state_reg, state_next;
   logic [AW-1:0]      w1, w2;
   logic               broadcast, conflict, in_idle;

   // Replay entry: the deferred lane-2 operation.
   logic               rp_we_reg;
   logic [AW-1:0]      rp_w_reg;
   logic [D_WIDTH-1:0] rp_wdata_reg;

   // Read-return tracking: which bank's read register feeds each lane's output.
   logic               rvalid1_reg, rvalid2_reg, rvalid1_next, rvalid2_next;
   logic               sel1_reg, sel2_reg, sel1_next, sel2_next;
   logic [D_WIDTH-1:0] hold1_reg, hold2_reg;
   logic [D_WIDTH-1:0] bank_rd [2];

   // Byte offset and the high address bits do not take part in decode.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_Addr1[D_WIDTH-1:AW+2], i_Addr1[1:0],
                               i_Addr2[D_WIDTH-1:AW+2], i_Addr2[1:0]};

   assign w1 = i_Addr1[AW+1:2];
   assign w2 = i_Addr2[AW+1:2];

   assign in_idle = (state_reg == ST_IDLE);
   assign o_Ready = in_idle;
   assign o_Stall = ~in_idle;

   // Two reads of the same word share one array access. Any other same-bank pair
   // needs two accesses.
   assign broadcast = i_Valid1 & i_Valid2 & ~i_WE1 & ~i_WE2 & (w1 == w2);
   assign conflict  = i_Valid1 & i_Valid2 & (w1[0] == w2[0]) & ~broadcast;

   // Next state and the lane/bank routing of read returns.
   always_comb begin
      state_next   = state_reg;
      rvalid1_next = 1'b0;
      rvalid2_next = 1'b0;
      sel1_next    = sel1_reg;
      sel2_next    = sel2_reg;
      if (state_reg == ST_REPLAY) begin
         state_next = ST_IDLE;
         if (!rp_we_reg) begin
            rvalid2_next = 1'b1;
            sel2_next    = rp_w_reg[0];
         end
      end else begin
         if (i_Valid1 && !i_WE1) begin
            rvalid1_next = 1'b1;
            sel1_next    = w1[0];
         end
         if (conflict) begin
            state_next = ST_REPLAY;
         end else if (i_Valid2 && !i_WE2) begin
            rvalid2_next = 1'b1;
            sel2_next    = w2[0];
         end
      end
   end

   // Control state, replay entry and output hold registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         rp_we_reg    <= 1'b0;
         rp_w_reg     <= '0;
         rp_wdata_reg <= '0;
         rvalid1_reg  <= 1'b0;
         rvalid2_reg  <= 1'b0;
         sel1_reg     <= 1'b0;
         sel2_reg     <= 1'b0;
         hold1_reg    <= '0;
         hold2_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         rvalid1_reg <= rvalid1_next;
         rvalid2_reg <= rvalid2_next;
         sel1_reg    <= sel1_next;
         sel2_reg    <= sel2_next;
         if (in_idle && conflict) begin
            rp_we_reg    <= i_WE2;
            rp_w_reg     <= w2;
            rp_wdata_reg <= i_WData2;
         end
         // Keep the returned word so that the output holds after the valid pulse.
         if (rvalid1_reg) hold1_reg <= bank_rd[sel1_reg];
         if (rvalid2_reg) hold2_reg <= bank_rd[sel2_reg];
      end
   end

   assign o_RValid1 = rvalid1_reg;
   assign o_RValid2 = rvalid2_reg;
   assign o_RD1     = rvalid1_reg ? bank_rd[sel1_reg] : hold1_reg;
   assign o_RD2     = rvalid2_reg ? bank_rd[sel2_reg] : hold2_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         localparam logic BANK = (gi != 0);

         logic [D_WIDTH-1:0] mem [DEPTH_B];
         logic [D_WIDTH-1:0] rd_reg;
         logic               en, we;
         logic [RW-1:0]      row;
         logic [D_WIDTH-1:0] wdata;

         // Select the single operation this bank performs this cycle.
         // A broadcast read has both lanes on the same word, so taking lane 1 covers both.
         always_comb begin
            en    = 1'b0;
            we    = 1'b0;
            row   = '0;
            wdata = '0;
            if (state_reg == ST_REPLAY) begin
               if (rp_w_reg[0] == BANK) begin
                  en    = 1'b1;
                  we    = rp_we_reg;
                  row   = rp_w_reg[AW-1:1];
                  wdata = rp_wdata_reg;
               end
            end else if (i_Valid1 && (w1[0] == BANK)) begin
               en    = 1'b1;
               we    = i_WE1;
               row   = w1[AW-1:1];
               wdata = i_WData1;
            end else if (i_Valid2 && !conflict && (w2[0] == BANK)) begin
               en    = 1'b1;
               we    = i_WE2;
               row   = w2[AW-1:1];
               wdata = i_WData2;
            end
            // Nothing reaches the array while reset is held.
            if (!rst_n) en = 1'b0;
         end

         // Single-port bank with a registered read.
         always_ff @(posedge clk) begin
            if (en) begin
               if (we) mem[row] <= wdata;
               else    rd_reg   <= mem[row];
            end
         end

         assign bank_rd[gi] = rd_reg;
      end
   endgenerate

endmodule
